icmp_share_sched: RTL and testbench

//  Time-shares one integer-compare datapath (LLVM icmp predicates) among NUM_REQ

---
 rtl/icmp_share_sched.sv | 114 +++++++++++
 tb/tb_icmp_share_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/icmp_share_sched.sv
// Shared LLVM icmp datapath: round-robin arbiter, operand stage,
// registered compare result tagged with the winning requester.
module icmp_share_sched #(
   parameter int NUM_REQ       = 3,
   parameter int ParamBitWidth = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ParamBitWidth-1:0] req_lhs,
   input  logic [NUM_REQ*ParamBitWidth-1:0] req_rhs,
   input  logic [NUM_REQ*6-1:0]             req_pred,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic                             rsp_ret,
   output logic                             rsp_err,
   output logic                             busy
);

   localparam int W  = ParamBitWidth;
   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]      r_ptr;
   logic               r_s1_v;
   logic [W-1:0]       r_s1_lhs;
   logic [W-1:0]       r_s1_rhs;
   logic [5:0]         r_s1_pred;
   logic [NUM_REQ-1:0] r_s1_id;
   logic [NUM_REQ-1:0] r_rsp_v;
   logic               r_rsp_ret;
   logic               r_rsp_err;

   logic [NUM_REQ-1:0] w_gnt;
   logic [PW-1:0]      w_win;
   logic [PW-1:0]      w_idx;
   logic               w_hit;
   logic               w_acc;
   logic               w_ret;
   logic               w_err;

   // Round-robin search starting one past the last winner.
   always_comb begin
      w_gnt = '0;
      w_win = '0;
      w_hit = 1'b0;
      w_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_hit && req_valid[w_idx]) begin
            w_hit = 1'b1;
            w_win = w_idx;
         end
      end
      if (w_hit && !stall) w_gnt[w_win] = 1'b1;
   end

   assign w_acc     = w_hit & ~stall;
   assign req_ready = w_gnt;

   // Predicate evaluation of the captured S1 entry.
   always_comb begin
      w_ret = 1'b0;
      w_err = 1'b0;
      unique case (r_s1_pred)
         6'd32:   w_ret = (r_s1_lhs == r_s1_rhs);
         6'd33:   w_ret = (r_s1_lhs != r_s1_rhs);
         6'd34:   w_ret = (r_s1_lhs >  r_s1_rhs);
         6'd35:   w_ret = (r_s1_lhs >= r_s1_rhs);
         6'd36:   w_ret = (r_s1_lhs <  r_s1_rhs);
         6'd37:   w_ret = (r_s1_lhs <= r_s1_rhs);
         6'd38:   w_ret = ($signed(r_s1_lhs) >  $signed(r_s1_rhs));
         6'd39:   w_ret = ($signed(r_s1_lhs) >= $signed(r_s1_rhs));
         6'd40:   w_ret = ($signed(r_s1_lhs) <  $signed(r_s1_rhs));
         6'd41:   w_ret = ($signed(r_s1_lhs) <= $signed(r_s1_rhs));
         default: w_err = 1'b1;
      endcase
   end

   // Pipeline registers; stall freezes every stage and the pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr     <= PW'(NUM_REQ - 1);
         r_s1_v    <= 1'b0;
         r_s1_lhs  <= '0;
         r_s1_rhs  <= '0;
         r_s1_pred <= '0;
         r_s1_id   <= '0;
         r_rsp_v   <= '0;
         r_rsp_ret <= 1'b0;
         r_rsp_err <= 1'b0;
      end else if (!stall) begin
         r_s1_v <= w_acc;
         if (w_acc) begin
            r_s1_lhs  <= req_lhs[int'(w_win)*W +: W];
            r_s1_rhs  <= req_rhs[int'(w_win)*W +: W];
            r_s1_pred <= req_pred[int'(w_win)*6 +: 6];
            r_s1_id   <= w_gnt;
            r_ptr     <= w_win;
         end
         r_rsp_v <= r_s1_v ? r_s1_id : '0;
         if (r_s1_v) begin
            r_rsp_ret <= w_ret;
            r_rsp_err <= w_err;
         end
      end
   end

   assign rsp_valid = r_rsp_v;
   assign rsp_ret   = r_rsp_ret;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_s1_v | (|r_rsp_v);

endmodule

// File: tb/tb_icmp_share_sched.sv
// Randomized bench for icmp_share_sched against a transaction-level
// model: expected grants, result order/timing and compare values.
module tb_icmp_share_sched;

   localparam int N = 3;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           stall = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_lhs = '0;
   logic [N*W-1:0] req_rhs = '0;
   logic [N*6-1:0] req_pred = '0;
   logic [N-1:0]   rsp_valid;
   logic           rsp_ret;
   logic           rsp_err;
   logic           busy;

   icmp_share_sched #(.NUM_REQ(N), .ParamBitWidth(W)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_lhs(req_lhs), .req_rhs(req_rhs), .req_pred(req_pred),
      .rsp_valid(rsp_valid), .rsp_ret(rsp_ret), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Accepted transaction; 'a' is the count of unstalled edges at accept.
   typedef struct {int id; int ret; int err; int a;} rsp_t;
   typedef struct {int id; int l; int r; int p;} dreq_t;

   rsp_t        q[$];
   dreq_t       dq[$];
   int          E;
   int          mptr;
   bit          pend[N];
   int          pl[N];
   int          pr[N];
   int          pp[N];
   int          last_ret;
   int          last_err;

   function automatic int sval(int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   function automatic void ref_eval(input int p, input int l, input int r,
                                    output int ret, output int err);
      int sl, sr;
      sl = sval(l);
      sr = sval(r);
      err = 0;
      ret = 0;
      case (p)
         32: ret = int'(l == r);
         33: ret = int'(l != r);
         34: ret = int'(l > r);
         35: ret = int'(l >= r);
         36: ret = int'(l < r);
         37: ret = int'(l <= r);
         38: ret = int'(sl > sr);
         39: ret = int'(sl >= sr);
         40: ret = int'(sl < sr);
         41: ret = int'(sl <= sr);
         default: err = 1;
      endcase
   endfunction

   function automatic int exp_grant();
      if (stall) return -1;
      for (int k = 1; k <= N; k++) begin
         if (pend[(mptr + k) % N]) return (mptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: starts and ends at a falling edge.
   task automatic cycle(input int p_stall, input int p_new);
      int g, ev, rt, er;
      bit s1;
      while (q.size() > 0 && q[0].a + 1 < E) void'(q.pop_front());
      ev = 0;
      s1 = 0;
      foreach (q[k]) begin
         if (q[k].a + 1 == E) begin
            ev = 1 << q[k].id;
            last_ret = q[k].ret;
            last_err = q[k].err;
         end
         if (q[k].a == E) s1 = 1;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_ret", 32'(rsp_ret), 32'(last_ret));
      chk("rsp_err", 32'(rsp_err), 32'(last_err));
      chk("busy", 32'(busy), 32'(s1 || ev != 0));

      stall = ($urandom % 100) < p_stall;
      while (dq.size() > 0 && !pend[dq[0].id]) begin
         pend[dq[0].id] = 1;
         pl[dq[0].id] = dq[0].l;
         pr[dq[0].id] = dq[0].r;
         pp[dq[0].id] = dq[0].p;
         void'(dq.pop_front());
      end
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && dq.size() == 0 && ($urandom % 100) < p_new) begin
            pend[i] = 1;
            pr[i] = int'($urandom % 256);
            pl[i] = ($urandom % 4 == 0) ? pr[i] : int'($urandom % 256);
            pp[i] = int'($urandom_range(43, 30));
         end
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i] = pend[i];
         req_lhs[i*W +: W] = W'(pl[i]);
         req_rhs[i*W +: W] = W'(pr[i]);
         req_pred[i*6 +: 6] = 6'(pp[i]);
      end
      #1;
      g = exp_grant();
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
      @(posedge clk);
      if (!stall) begin
         E++;
         if (g >= 0) begin
            ref_eval(pp[g], pl[g], pr[g], rt, er);
            q.push_back('{g, rt, er, E});
            mptr = g;
            pend[g] = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      q.delete();
      dq.delete();
      E = 0;
      mptr = N - 1;
      last_ret = 0;
      last_err = 0;
      for (int i = 0; i < N; i++) pend[i] = 0;
      req_valid = '0;
      stall = 1'b0;
   endtask

   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ret_err", {30'd0, rsp_ret, rsp_err}, 32'd0);
      model_reset();
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) dq.push_back('{i, 7, 7, 32});
   endtask

   initial begin
      model_reset();
      #1;
      chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_ret_err", {30'd0, rsp_ret, rsp_err}, 32'd0);
      chk("init_ready", 32'(req_ready), 32'd0);
      #11 rst = 1'b0;
      @(negedge clk);

      dq.push_back('{0, 5, 5, 37});
      dq.push_back('{1, 6, 5, 37});
      dq.push_back('{2, 8'h80, 8'h01, 40});
      dq.push_back('{0, 8'h80, 8'h01, 36});
      dq.push_back('{1, 8'hFF, 8'hFF, 39});
      dq.push_back('{2, 1, 1, 31});
      dq.push_back('{0, 1, 1, 42});
      dq.push_back('{1, 3, 3, 32});
      repeat (16) cycle(0, 0);

      repeat (12) cycle(0, 100);
      repeat (2) cycle(0, 100);
      repeat (3) cycle(100, 100);
      repeat (6) cycle(0, 100);

      dq.push_back('{2, 1, 2, 36});
      dq.push_back('{0, 2, 1, 34});
      repeat (6) cycle(0, 0);

      repeat (400) cycle(20, 50);

      repeat (5) cycle(0, 100);
      mid_reset();
      repeat (8) cycle(0, 0);

      repeat (300) cycle(15, 60);
      repeat (6) cycle(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
